// File: rtl/chess_pkg.sv
// Shared chess definitions: square code fields, FSM states, key actions
// and the saturating cursor-step helper.
package chess_pkg;

   localparam int SQ_IDX_W  = 6;
   localparam int COLOR_BIT = 3;

   localparam logic [7:0]          EMPTY_CODE   = 8'h00;
   localparam logic [SQ_IDX_W-1:0] CURSOR_RESET = 6'd60;

   typedef enum logic [2:0] {
      PT_EMPTY  = 3'd0,
      PT_PAWN   = 3'd1,
      PT_KNIGHT = 3'd2,
      PT_BISHOP = 3'd3,
      PT_ROOK   = 3'd4,
      PT_QUEEN  = 3'd5,
      PT_KING   = 3'd6
   } piece_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PICKED,
      ST_WRITE_DST,
      ST_WRITE_SRC
   } state_t;

   typedef enum logic [2:0] {
      ACT_NONE,
      ACT_SELECT,
      ACT_LEFT,
      ACT_RIGHT,
      ACT_UP,
      ACT_DOWN
   } action_t;

   // Moves the cursor one step; the board edges saturate instead of wrapping.
   function automatic logic [SQ_IDX_W-1:0] step_cursor(input logic [SQ_IDX_W-1:0] sq,
                                                       input action_t act);
      logic [2:0] row;
      logic [2:0] col;
      row = sq[5:3];
      col = sq[2:0];
      case (act)
         ACT_LEFT:  if (col != 3'd0) col = col - 3'd1;
         ACT_RIGHT: if (col != 3'd7) col = col + 3'd1;
         ACT_UP:    if (row != 3'd0) row = row - 3'd1;
         ACT_DOWN:  if (row != 3'd7) row = row + 3'd1;
         default:   ;
      endcase
      return {row, col};
   endfunction

endpackage

// File: rtl/chess_move_controller_if.sv
// Board-side bus of the move controller: buttons and layout in,
// cursor/selection status and the single-square write port out.
interface chess_move_controller_if #(
   parameter int SQUARE_WIDTH = 8,
   parameter int MATRIX_WIDTH = 64 * 8
);
   import chess_pkg::*;

   logic                    KeyLeft;
   logic                    KeyRight;
   logic                    KeyUp;
   logic                    KeyDown;
   logic                    KeySelect;
   logic [MATRIX_WIDTH-1:0] Layout;
   logic [SQ_IDX_W-1:0]     CursorSquare;
   logic [SQ_IDX_W-1:0]     SelectedSquare;
   logic                    SelectValid;
   logic                    WrEn;
   logic [SQ_IDX_W-1:0]     WrAddr;
   logic [SQUARE_WIDTH-1:0] WrData;
   logic                    Turn;
   logic                    MoveDone;

   modport slave (
      input  KeyLeft, KeyRight, KeyUp, KeyDown, KeySelect, Layout,
      output CursorSquare, SelectedSquare, SelectValid, WrEn, WrAddr, WrData, Turn, MoveDone
   );

   modport master (
      output KeyLeft, KeyRight, KeyUp, KeyDown, KeySelect, Layout,
      input  CursorSquare, SelectedSquare, SelectValid, WrEn, WrAddr, WrData, Turn, MoveDone
   );

endinterface

// File: rtl/key_edge_sync.sv
// Two-flop synchronizer plus rising-edge pulse for one raw button.
// A key already high when reset releases must be let go before it can fire.
module key_edge_sync (
   input  logic clock,
   input  logic resetApp,
   input  logic i_key,
   output logic o_pulse
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;
   logic r_primed;
   logic r_armed;

   // NOTE: async reset in the sensitivity list, and <= for every flop so all
   // stages sample the pre-edge values of their neighbours.
   always_ff @(posedge clock or posedge resetApp) begin
      if (resetApp) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_prev   <= 1'b0;
         r_primed <= 1'b0;
         r_armed  <= 1'b0;
      end else begin
         r_sync1  <= i_key;
         r_sync2  <= r_sync1;
         r_prev   <= r_sync2;
         r_primed <= 1'b1;
         // r_sync1 holds a real sample only once r_primed is set.
         r_armed  <= r_armed | (r_primed & ~r_sync1);
      end
   end

   assign o_pulse = r_sync2 & ~r_prev & r_armed;

endmodule

// File: rtl/chess_move_controller.sv
// Cursor navigation and pick/place FSM: a completed move writes the piece to
// its destination, clears the source square, then hands the turn over.
module chess_move_controller
   import chess_pkg::*;
#(
   parameter int CHESS_SQUARES = 64,
   parameter int SQUARE_WIDTH  = 8,
   parameter int MATRIX_WIDTH  = CHESS_SQUARES * SQUARE_WIDTH
) (
   input  logic clock,
   input  logic resetApp,
   chess_move_controller_if.slave io_bus
);

   state_t                  r_state;
   state_t                  w_state_nxt;
   action_t                 w_action;
   logic [SQ_IDX_W-1:0]     r_cursor;
   logic [SQ_IDX_W-1:0]     r_selected;
   logic [SQ_IDX_W-1:0]     r_wr_addr;
   logic [SQUARE_WIDTH-1:0] r_wr_data;
   logic                    r_sel_valid;
   logic                    r_turn;
   logic                    w_pls_select;
   logic                    w_pls_left;
   logic                    w_pls_right;
   logic                    w_pls_up;
   logic                    w_pls_down;
   logic [MATRIX_WIDTH-1:0] w_layout;
   logic [SQUARE_WIDTH-1:0] w_squares [CHESS_SQUARES];
   logic [SQUARE_WIDTH-1:0] w_cur_code;
   logic [SQUARE_WIDTH-1:0] w_sel_code;
   logic                    w_ui_state;
   logic                    w_select;
   logic                    w_cur_empty;
   logic                    w_cur_own;
   logic                    w_wr_en;
   logic                    w_move_done;
   logic                    w_unused_code_bits;

   key_edge_sync u_sync_select (.clock(clock), .resetApp(resetApp), .i_key(io_bus.KeySelect), .o_pulse(w_pls_select));
   key_edge_sync u_sync_left   (.clock(clock), .resetApp(resetApp), .i_key(io_bus.KeyLeft),   .o_pulse(w_pls_left));
   key_edge_sync u_sync_right  (.clock(clock), .resetApp(resetApp), .i_key(io_bus.KeyRight),  .o_pulse(w_pls_right));
   key_edge_sync u_sync_up     (.clock(clock), .resetApp(resetApp), .i_key(io_bus.KeyUp),     .o_pulse(w_pls_up));
   key_edge_sync u_sync_down   (.clock(clock), .resetApp(resetApp), .i_key(io_bus.KeyDown),   .o_pulse(w_pls_down));

   assign w_layout = io_bus.Layout;

   for (genvar g = 0; g < CHESS_SQUARES; g++) begin : g_square
      assign w_squares[g] = w_layout[g*SQUARE_WIDTH +: SQUARE_WIDTH];
   end

   assign w_cur_code         = w_squares[r_cursor];
   assign w_sel_code         = w_squares[r_selected];
   assign w_cur_empty        = (piece_t'(w_cur_code[2:0]) == PT_EMPTY);
   assign w_cur_own          = !w_cur_empty && (w_cur_code[COLOR_BIT] == r_turn);
   assign w_unused_code_bits = ^w_cur_code[SQUARE_WIDTH-1:COLOR_BIT+1];

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_action = ACT_NONE;
      if      (w_pls_select) w_action = ACT_SELECT;
      else if (w_pls_left)   w_action = ACT_LEFT;
      else if (w_pls_right)  w_action = ACT_RIGHT;
      else if (w_pls_up)     w_action = ACT_UP;
      else if (w_pls_down)   w_action = ACT_DOWN;
   end

   assign w_ui_state = (r_state == ST_IDLE) || (r_state == ST_PICKED);
   assign w_select   = (w_action == ACT_SELECT);

   always_ff @(posedge clock or posedge resetApp) begin
      if (resetApp) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_select && w_cur_own) w_state_nxt = ST_PICKED;
         end
         ST_PICKED: begin
            if (w_select) begin
               if (r_cursor == r_selected) w_state_nxt = ST_IDLE;
               else if (w_cur_own)         w_state_nxt = ST_PICKED;
               else                        w_state_nxt = ST_WRITE_DST;
            end
         end
         ST_WRITE_DST: w_state_nxt = ST_WRITE_SRC;
         ST_WRITE_SRC: w_state_nxt = ST_IDLE;
         default:      w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_wr_en     = 1'b0;
      w_move_done = 1'b0;
      unique case (r_state)
         ST_WRITE_DST: w_wr_en = 1'b1;
         ST_WRITE_SRC: begin
            w_wr_en     = 1'b1;
            w_move_done = 1'b1;
         end
         default: ;
      endcase
   end

   // Write address/data are loaded on the edge that enters each write state.
   always_ff @(posedge clock or posedge resetApp) begin
      if (resetApp) begin
         r_cursor    <= CURSOR_RESET;
         r_selected  <= '0;
         r_sel_valid <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_turn      <= 1'b0;
      end else begin
         if (w_ui_state) r_cursor <= step_cursor(r_cursor, w_action);
         unique case (r_state)
            ST_IDLE: begin
               if (w_state_nxt == ST_PICKED) begin
                  r_selected  <= r_cursor;
                  r_sel_valid <= 1'b1;
               end
            end
            ST_PICKED: begin
               if (w_select) begin
                  unique case (w_state_nxt)
                     ST_IDLE:   r_sel_valid <= 1'b0;
                     ST_PICKED: r_selected  <= r_cursor;
                     default: begin
                        r_wr_addr <= r_cursor;
                        r_wr_data <= w_sel_code;
                     end
                  endcase
               end
            end
            ST_WRITE_DST: begin
               r_wr_addr <= r_selected;
               r_wr_data <= SQUARE_WIDTH'(EMPTY_CODE);
            end
            ST_WRITE_SRC: begin
               r_turn      <= ~r_turn;
               r_sel_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign io_bus.CursorSquare   = r_cursor;
   assign io_bus.SelectedSquare = r_selected;
   assign io_bus.SelectValid    = r_sel_valid;
   assign io_bus.WrEn           = w_wr_en;
   assign io_bus.WrAddr         = r_wr_addr;
   assign io_bus.WrData         = r_wr_data;
   assign io_bus.Turn           = r_turn;
   assign io_bus.MoveDone       = w_move_done;

endmodule

// File: tb/tb_chess_move_controller.sv
// Self-checking bench for chess_move_controller: cursor vector table,
// pick/cancel/reselect/move sequences, held-key and mid-write reset cases.
module tb_chess_move_controller;
   import chess_pkg::*;

   localparam int NSQ = 64;
   localparam int SQW = 8;
   localparam int MW  = NSQ * SQW;

   localparam logic [4:0] K_SEL = 5'b00001;
   localparam logic [4:0] K_L   = 5'b00010;
   localparam logic [4:0] K_R   = 5'b00100;
   localparam logic [4:0] K_U   = 5'b01000;
   localparam logic [4:0] K_D   = 5'b10000;

   typedef struct {
      logic [4:0] keys;
      logic [5:0] exp_cursor;
   } vec_t;

   typedef struct {
      logic [5:0]     addr;
      logic [SQW-1:0] data;
   } wr_t;

   logic clock = 1'b0;
   logic resetApp;

   int checks   = 0;
   int failures = 0;

   vec_t       vecs[$];
   logic [5:0] cur_q[$];
   wr_t        wr_q[$];

   always #5 clock = ~clock;

   chess_move_controller_if #(.SQUARE_WIDTH(SQW), .MATRIX_WIDTH(MW)) bus ();

   chess_move_controller #(
      .CHESS_SQUARES(NSQ),
      .SQUARE_WIDTH (SQW),
      .MATRIX_WIDTH (MW)
   ) dut (
      .clock   (clock),
      .resetApp(resetApp),
      .io_bus  (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_keys(input logic [4:0] m);
      bus.KeySelect = m[0];
      bus.KeyLeft   = m[1];
      bus.KeyRight  = m[2];
      bus.KeyUp     = m[3];
      bus.KeyDown   = m[4];
   endtask

   // Returns on the falling edge right after the action's clock edge.
   task automatic press(input logic [4:0] m);
      repeat (2) @(negedge clock);
      set_keys(m);
      repeat (3) @(negedge clock);
      set_keys(5'b0);
   endtask

   task automatic do_reset(input logic [4:0] held);
      @(negedge clock);
      resetApp = 1'b1;
      set_keys(held);
      repeat (2) @(negedge clock);
      resetApp = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic put_square(input int idx, input logic [SQW-1:0] code);
      bus.Layout[idx*SQW +: SQW] = code;
   endtask

   // Write-port scoreboard: every WrEn cycle must match the next queued write.
   always @(negedge clock) begin
      if (bus.WrEn === 1'b1) begin
         if (wr_q.size() == 0) begin
            check("unexpected write WrEn", 32'(bus.WrEn), 32'd0);
         end else begin
            wr_t w;
            w = wr_q.pop_front();
            check("write WrAddr", 32'(bus.WrAddr), 32'(w.addr));
            check("write WrData", 32'(bus.WrData), 32'(w.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetApp   = 1'b1;
      set_keys(5'b0);
      bus.Layout = '0;
      put_square(51, 8'h01);
      put_square(52, 8'h01);
      put_square(59, 8'h09);
      put_square(60, 8'h06);

      // Reset values while reset is held
      repeat (2) @(negedge clock);
      check("reset CursorSquare",   32'(bus.CursorSquare),   32'd60);
      check("reset SelectedSquare", 32'(bus.SelectedSquare), 32'd0);
      check("reset SelectValid",    32'(bus.SelectValid),    32'd0);
      check("reset WrEn",           32'(bus.WrEn),           32'd0);
      check("reset WrAddr",         32'(bus.WrAddr),         32'd0);
      check("reset WrData",         32'(bus.WrData),         32'd0);
      check("reset Turn",           32'(bus.Turn),           32'd0);
      check("reset MoveDone",       32'(bus.MoveDone),       32'd0);
      resetApp = 1'b0;
      repeat (2) @(negedge clock);

      // Cursor navigation table, starting from square 60
      vecs.push_back('{K_L, 6'd59});
      vecs.push_back('{K_L, 6'd58});
      vecs.push_back('{K_L, 6'd57});
      vecs.push_back('{K_L, 6'd56});
      vecs.push_back('{K_L, 6'd56});
      vecs.push_back('{K_R, 6'd57});
      vecs.push_back('{K_U, 6'd49});
      vecs.push_back('{K_D, 6'd57});
      vecs.push_back('{K_D, 6'd57});
      vecs.push_back('{K_R | K_U, 6'd58});
      vecs.push_back('{K_U | K_D, 6'd50});
      vecs.push_back('{K_R, 6'd51});
      vecs.push_back('{K_R, 6'd52});
      vecs.push_back('{K_R, 6'd53});
      vecs.push_back('{K_R, 6'd54});
      vecs.push_back('{K_R, 6'd55});
      vecs.push_back('{K_R, 6'd55});
      vecs.push_back('{K_U, 6'd47});
      vecs.push_back('{K_U, 6'd39});
      vecs.push_back('{K_U, 6'd31});
      vecs.push_back('{K_U, 6'd23});
      vecs.push_back('{K_U, 6'd15});
      vecs.push_back('{K_U, 6'd7});
      vecs.push_back('{K_U, 6'd7});
      vecs.push_back('{K_SEL | K_L, 6'd7});

      for (int i = 0; i < vecs.size(); i++) begin
         cur_q.push_back(vecs[i].exp_cursor);
         press(vecs[i].keys);
         check($sformatf("vec%0d CursorSquare", i), 32'(bus.CursorSquare), 32'(cur_q.pop_front()));
      end
      check("table SelectValid", 32'(bus.SelectValid), 32'd0);

      // Simultaneous Left+Down from 60: Left only
      do_reset(5'b0);
      press(K_L | K_D);
      check("left+down CursorSquare", 32'(bus.CursorSquare), 32'd59);
      repeat (4) @(negedge clock);
      check("left+down no late down", 32'(bus.CursorSquare), 32'd59);

      // Select opponent piece (black pawn at 59) on white's turn
      press(K_SEL);
      check("opp select SelectValid", 32'(bus.SelectValid), 32'd0);
      check("opp select WrEn",        32'(bus.WrEn),        32'd0);
      press(K_L);
      check("opp select still idle", 32'(bus.SelectValid), 32'd0);
      press(K_R);

      // Pick at 52, cancel, pick again, reselect 51, reselect 52
      press(K_U);
      press(K_R);
      check("nav to 52", 32'(bus.CursorSquare), 32'd52);
      press(K_SEL);
      check("pick SelectValid",    32'(bus.SelectValid),    32'd1);
      check("pick SelectedSquare", 32'(bus.SelectedSquare), 32'd52);
      press(K_SEL);
      check("cancel SelectValid", 32'(bus.SelectValid), 32'd0);
      check("cancel WrEn",        32'(bus.WrEn),        32'd0);
      press(K_SEL);
      press(K_L);
      press(K_SEL);
      check("reselect SelectedSquare", 32'(bus.SelectedSquare), 32'd51);
      check("reselect SelectValid",    32'(bus.SelectValid),    32'd1);
      press(K_R);
      press(K_SEL);
      check("reselect back 52", 32'(bus.SelectedSquare), 32'd52);

      // Move pawn 52 -> 36
      press(K_U);
      press(K_U);
      check("nav to 36", 32'(bus.CursorSquare), 32'd36);
      wr_q.push_back('{6'd36, 8'h01});
      wr_q.push_back('{6'd52, 8'h00});
      press(K_SEL);
      check("dst WrEn",     32'(bus.WrEn),     32'd1);
      check("dst MoveDone", 32'(bus.MoveDone), 32'd0);
      @(negedge clock);
      check("src WrEn",     32'(bus.WrEn),     32'd1);
      check("src MoveDone", 32'(bus.MoveDone), 32'd1);
      check("src Turn",     32'(bus.Turn),     32'd0);
      @(negedge clock);
      check("post WrEn",        32'(bus.WrEn),        32'd0);
      check("post MoveDone",    32'(bus.MoveDone),    32'd0);
      check("post Turn",        32'(bus.Turn),        32'd1);
      check("post SelectValid", 32'(bus.SelectValid), 32'd0);
      check("post WrAddr hold", 32'(bus.WrAddr),      32'd52);

      // Key held through reset release produces no action until re-pressed
      do_reset(K_L);
      repeat (6) @(negedge clock);
      check("held key no action", 32'(bus.CursorSquare), 32'd60);
      set_keys(5'b0);
      press(K_L);
      check("re-press acts", 32'(bus.CursorSquare), 32'd59);

      // Reset during WRITE_DST: king 60 captures 59, aborted by reset
      do_reset(5'b0);
      press(K_SEL);
      check("king pick", 32'(bus.SelectValid), 32'd1);
      press(K_L);
      wr_q.push_back('{6'd59, 8'h06});
      press(K_SEL);
      check("abort dst WrEn", 32'(bus.WrEn), 32'd1);
      #2;
      resetApp = 1'b1;
      #1;
      check("abort WrEn",         32'(bus.WrEn),         32'd0);
      check("abort CursorSquare", 32'(bus.CursorSquare), 32'd60);
      check("abort Turn",         32'(bus.Turn),         32'd0);
      check("abort SelectValid",  32'(bus.SelectValid),  32'd0);
      @(negedge clock);
      resetApp = 1'b0;
      repeat (4) @(negedge clock);
      check("abort no src write", 32'(bus.WrEn), 32'd0);
      check("write queue drained", 32'(wr_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
